// File: rtl/neuron_pkg.sv
// Shared definitions for the single-neuron datapaths: FSM states, default
// widths, and the accumulator sizing rule.
package neuron_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      ACT,
      DONE
   } state_t;

   localparam int DEF_N_IN  = 4;
   localparam int DEF_DW    = 8;
   localparam int DEF_ACC_W = 20;

   // Signed product (2*DW+1), growth over n_in terms, plus one bit for the bias add.
   function automatic int min_acc_w(input int n_in, input int dw);
      return 2 * dw + 1 + $clog2(n_in) + 1;
   endfunction

endpackage

// File: rtl/relu_sat.sv
// Combinational fixed-point rescale and ReLU clamp: a signed ACC_W-bit sum is
// arithmetically shifted right by SHIFT, then clamped into DW-bit unsigned.
module relu_sat
   import neuron_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int DW    = DEF_DW,
   parameter int SHIFT = 0
) (
   input  logic signed [ACC_W-1:0] i_sum,
   output logic        [DW-1:0]    o_act
);

   logic signed [ACC_W-1:0] w_shifted;

   assign w_shifted = i_sum >>> SHIFT;

   // NOTE: o_act gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      o_act = w_shifted[DW-1:0];
      if (w_shifted[ACC_W-1]) begin
         o_act = '0;
      end else if (|w_shifted[ACC_W-2:DW]) begin
         o_act = '1;
      end
   end

endmodule

// File: rtl/neuron_mac.sv
// Sequential single neuron: one shared MAC iterated over N_IN latched inputs,
// then bias, shift and ReLU clamp; o_ready holds until the next start or reset.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int DW    = DEF_DW,
   parameter int ACC_W = DEF_ACC_W,
   parameter int SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_new,
   input  logic [N_IN*DW-1:0]   i_x,
   input  logic [N_IN*DW-1:0]   i_w,
   input  logic [2*DW-1:0]      i_bias,
   output logic [DW-1:0]        o_out,
   output logic                 o_ready
);

   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int PW    = 2 * DW + 1;

   if (ACC_W < min_acc_w(N_IN, DW)) begin : g_acc_w_check
      $error("neuron_mac: ACC_W too small for N_IN and DW");
   end

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [N_IN*DW-1:0]      r_x;
   logic [N_IN*DW-1:0]      r_w;
   logic [2*DW-1:0]         r_bias;
   logic signed [ACC_W-1:0] r_acc;
   logic [IDX_W-1:0]        r_idx;
   logic [DW-1:0]           r_out;
   logic                    r_ready;

   logic [DW-1:0]           w_xi;
   logic [DW-1:0]           w_wi;
   logic signed [PW-1:0]    w_x_s;
   logic signed [PW-1:0]    w_w_s;
   logic signed [PW-1:0]    w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_bias_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic [DW-1:0]           w_act;
   logic                    w_last;

   assign w_xi   = r_x[r_idx*DW +: DW];
   assign w_wi   = r_w[r_idx*DW +: DW];
   assign w_last = (r_idx == IDX_W'(N_IN - 1));

   // Input is unsigned (zero-extend), weight is signed (sign-extend); the
   // product always fits in PW bits.
   assign w_x_s      = {{(PW-DW){1'b0}}, w_xi};
   assign w_w_s      = {{(PW-DW){w_wi[DW-1]}}, w_wi};
   assign w_prod     = w_x_s * w_w_s;
   assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
   assign w_bias_ext = {{(ACC_W-2*DW){r_bias[2*DW-1]}}, r_bias};
   assign w_sum      = r_acc + w_bias_ext;

   relu_sat #(
      .ACC_W (ACC_W),
      .DW    (DW),
      .SHIFT (SHIFT)
   ) u_relu_sat (
      .i_sum (w_sum),
      .o_act (w_act)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (i_new) begin
         w_state_nxt = ACC;
      end else begin
         case (r_state)
            ACC:     if (w_last) w_state_nxt = ACT;
            ACT:     w_state_nxt = DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_w     <= '0;
         r_bias  <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_out   <= '0;
         r_ready <= 1'b0;
      end else if (i_new) begin
         // A start in any state restarts from the newly presented operands.
         r_x     <= i_x;
         r_w     <= i_w;
         r_bias  <= i_bias;
         r_acc   <= '0;
         r_idx   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               r_acc <= r_acc + w_prod_ext;
               r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            ACT: begin
               r_out   <= w_act;
               r_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_out   = r_out;
   assign o_ready = r_ready;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: an unscaled instance and a SHIFT=4 instance
// share the same stimulus; expected values are hand-computed.
module tb_neuron_mac;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        i_new  = 1'b0;
   logic [31:0] i_x    = '0;
   logic [31:0] i_w    = '0;
   logic [15:0] i_bias = '0;
   logic [7:0]  out0;
   logic [7:0]  out4;
   logic        rdy0;
   logic        rdy4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   neuron_mac #(.N_IN(4), .DW(8), .ACC_W(20), .SHIFT(0)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_new   (i_new),
      .i_x     (i_x),
      .i_w     (i_w),
      .i_bias  (i_bias),
      .o_out   (out0),
      .o_ready (rdy0)
   );

   neuron_mac #(.N_IN(4), .DW(8), .ACC_W(20), .SHIFT(4)) u_dut_s4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_new   (i_new),
      .i_x     (i_x),
      .i_w     (i_w),
      .i_bias  (i_bias),
      .o_out   (out4),
      .o_ready (rdy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] pack(input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2, input logic [7:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   // Called at a falling edge; the next rising edge samples the start.
   task automatic pulse_new(input logic [31:0] x, input logic [31:0] w, input logic [15:0] b);
      i_x    = x;
      i_w    = w;
      i_bias = b;
      i_new  = 1'b1;
      @(negedge clk);
      i_new  = 1'b0;
   endtask

   // Counts rising edges after the start edge until ready, bounded.
   task automatic measure(input string tag, input int lat_exp,
                          input logic [7:0] o0, input logic [7:0] o4);
      int lat;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (rdy0) begin
            lat = k;
            break;
         end
      end
      check({tag, ".lat"},    lat,  lat_exp);
      check({tag, ".out"},    out0, o0);
      check({tag, ".out_s4"}, out4, o4);
      check({tag, ".rdy_s4"}, rdy4, 1);
   endtask

   initial begin
      logic ok;
      logic seen;

      repeat (2) @(negedge clk);
      check("rst.out",    out0, 0);
      check("rst.rdy",    rdy0, 0);
      check("rst.out_s4", out4, 0);
      check("rst.rdy_s4", rdy4, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle.rdy", rdy0, 0);

      pulse_new(pack(10, 10, 10, 10), pack(2, 2, 2, 2), 16'd0);
      measure("basic", 5, 80, 5);
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out0 !== 8'd80 || rdy0 !== 1'b1) ok = 1'b0;
      end
      check("basic.hold", ok, 1);

      pulse_new(pack(10, 20, 30, 40), pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), 16'd0);
      measure("neg_clamp", 5, 0, 0);

      pulse_new(pack(255, 255, 255, 255), pack(127, 127, 127, 127), 16'd0);
      measure("pos_sat", 5, 255, 255);

      pulse_new(32'd0, 32'd0, 16'd300);
      measure("bias_sat", 5, 255, 18);

      pulse_new(32'd0, 32'd0, 16'hFFFB);
      measure("bias_neg", 5, 0, 0);

      pulse_new(pack(20, 20, 20, 20), pack(16, 16, 16, 16), 16'd0);
      measure("scale", 5, 255, 80);

      pulse_new(pack(20, 20, 20, 20), pack(16, 16, 16, 16), 16'd16);
      measure("scale_bias", 5, 255, 81);

      // 10 - 6 + 15 + 28 + 3 = 50
      pulse_new(pack(1, 2, 3, 4), pack(10, 8'hFD, 5, 7), 16'd3);
      measure("mixed", 5, 50, 3);

      pulse_new(pack(200, 0, 0, 0), pack(1, 0, 0, 0), 16'd0);
      measure("x_unsigned", 5, 200, 12);

      pulse_new(pack(0, 0, 0, 9), pack(0, 0, 0, 3), 16'd0);
      measure("last_elem", 5, 27, 1);

      // Restart at T2: the first result (80) must never appear.
      pulse_new(pack(10, 10, 10, 10), pack(2, 2, 2, 2), 16'd0);
      @(negedge clk);
      pulse_new(pack(5, 5, 5, 5), pack(1, 1, 1, 1), 16'd0);
      measure("restart", 5, 20, 1);

      pulse_new(pack(3, 3, 3, 3), pack(3, 3, 3, 3), 16'd0);
      check("done_new.rdy", rdy0, 0);
      measure("done_new", 5, 36, 2);

      i_x    = pack(10, 10, 10, 10);
      i_w    = pack(2, 2, 2, 2);
      i_bias = 16'd0;
      i_new  = 1'b1;
      seen   = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rdy0) seen = 1'b1;
      end
      check("held.rdy", seen, 0);
      i_new = 1'b0;
      measure("held_release", 5, 80, 5);

      // Reset between T2 and T3 of a computation that would give 20.
      pulse_new(pack(5, 5, 5, 5), pack(1, 1, 1, 1), 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid.out", out0, 0);
      check("rst_mid.rdy", rdy0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rdy0) seen = 1'b1;
      end
      check("rst_mid.no_rdy", seen, 0);
      check("rst_mid.out_after", out0, 0);

      pulse_new(pack(1, 2, 3, 4), pack(10, 8'hFD, 5, 7), 16'd3);
      i_x    = pack(255, 255, 255, 255);
      i_w    = pack(127, 127, 127, 127);
      i_bias = 16'h7FFF;
      measure("iso_acc", 5, 50, 3);
      i_x    = 32'd0;
      i_w    = pack(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      i_bias = 16'h8000;
      repeat (5) @(negedge clk);
      check("iso_done.out", out0, 50);
      check("iso_done.rdy", rdy0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
